// File: rtl/rotation_seq.sv
// Purpose : iterative CORDIC rotation, polar (r, angle) in -> saturated cartesian (x, y) out.
// Latency : valid_o pulses N+1 cycles after the accepting edge; one sample per N+2 cycles.
// Backpr. : ready_o is high only when idle; valid_i while busy is ignored and the sample is dropped.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   valid_i / ready_o    input handshake (accept on valid_i && ready_o)
//   r_i                  unsigned magnitude, DW bits
//   angle_i              {quadrant[1:0], in-quadrant angle[AW-1:0]}, 2**AW units = pi/2
//   valid_o              one-cycle result strobe
//   x_o / y_o            signed result, held until the next result
module rotation_seq #(
    parameter int              N    = 16,
    parameter int              DW   = 16,
    parameter int              AW   = 16,
    // Entry i lives at bits [i*AW +: AW]: round(atan(2**-i) * 2**AW / (pi/2)).
    parameter logic [N*AW-1:0] ATAN = {16'd1,    16'd3,    16'd5,    16'd10,
                                       16'd20,   16'd41,   16'd81,   16'd163,
                                       16'd326,  16'd652,  16'd1303, 16'd2604,
                                       16'd5188, 16'd10221, 16'd19344, 16'd32768},
    parameter int              KW   = DW,
    parameter int unsigned     K    = $rtoi(0.6072529 * (2.0 ** KW) + 0.5)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] r_i,
    input  logic [AW+1:0] angle_i,
    output logic          valid_o,
    output logic [DW-1:0] x_o,
    output logic [DW-1:0] y_o
);

    localparam int XW = DW + 2;              // x/y datapath: headroom for the ~1.647 CORDIC gain
    localparam int ZW = AW + 1;              // residual angle, signed
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = XW + KW + 1;         // gain-compensation product
    localparam int SW = DW + 3;              // scaled value, room to negate before saturation

    localparam logic [KW-1:0]        K_L  = KW'(K);
    localparam logic signed [SW-1:0] SMAX = SW'((1 <<< (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = -SMAX;

    typedef enum logic [1:0] {IDLE, ITER, SCALE} state_t;

    state_t                state_q, state_d;
    logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]  z_q, z_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            quad_q, quad_d;
    logic [DW-1:0]         xo_q, xo_d, yo_q, yo_d;
    logic                  vo_q, vo_d;

    // Combinational helpers
    logic signed [XW-1:0]  xs, ys;
    logic signed [ZW-1:0]  atan_i;
    logic signed [PW-1:0]  prod_x, prod_y;
    logic signed [SW-1:0]  sx, sy, mx, my;

    // Symmetric clamp: the most negative code is never produced.
    function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SMAX)      return SMAX[DW-1:0];
        else if (v < SMIN) return SMIN[DW-1:0];
        else               return v[DW-1:0];
    endfunction

    always_comb begin
        xs     = x_q >>> cnt_q;
        ys     = y_q >>> cnt_q;
        atan_i = $signed({1'b0, ATAN[cnt_q*AW +: AW]});

        prod_x = PW'(x_q) * PW'($signed({1'b0, K_L}));
        prod_y = PW'(y_q) * PW'($signed({1'b0, K_L}));
        sx     = SW'(prod_x >>> KW);
        sy     = SW'(prod_y >>> KW);

        // Rotation was done inside the first quadrant; fold in the quadrant
        // by a multiple of 90 degrees.
        unique case (quad_q)
            2'd0:    begin mx =  sx; my =  sy; end
            2'd1:    begin mx = -sy; my =  sx; end
            2'd2:    begin mx = -sx; my = -sy; end
            default: begin mx =  sy; my = -sx; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        quad_d  = quad_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        vo_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    quad_d  = angle_i[AW+1:AW];
                    x_d     = XW'(r_i);
                    y_d     = '0;
                    z_d     = $signed({1'b0, angle_i[AW-1:0]});
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                // Drive the residual angle toward zero.
                if (!z_q[ZW-1]) begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + atan_i;
                end
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = SCALE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            SCALE: begin
                xo_d    = sat(mx);
                yo_d    = sat(my);
                vo_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            quad_q  <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            vo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            quad_q  <= quad_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            vo_q    <= vo_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = vo_q;
    assign x_o     = xo_q;
    assign y_o     = yo_q;

endmodule
